// File: rtl/scaler_h_lerp_if.sv
// Pixel stream bundle between the pixel source, the horizontal scaler and the sink.
// The master drives the input stream and observes the scaled stream; the slave is the scaler.
interface scaler_h_lerp_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] di_i;
  logic                  de_i;
  logic                  hs_i;
  logic                  vs_i;
  logic [DATA_WIDTH-1:0] do_o;
  logic                  de_o;
  logic                  hs_o;
  logic                  vs_o;

  modport master (output di_i, de_i, hs_i, vs_i, input do_o, de_o, hs_o, vs_o);
  modport slave  (input di_i, de_i, hs_i, vs_i, output do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/scaler_h_lerp.sv
// Horizontal 2-tap linear-interpolation scaler for a single-component pixel stream.
// Optional build macro SCALER_H_ROUND_EN selects round-half-up output instead of truncation.
module scaler_h_lerp #(
  parameter int PIXEL_STEP        = 4096,
  parameter int TABLE_INPUT_WIDTH = 10,
  parameter int DATA_WIDTH        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] scale_step,
  scaler_h_lerp_if.slave bus
);
  localparam int FB = $clog2(PIXEL_STEP);
  localparam int T  = TABLE_INPUT_WIDTH;
  localparam int AW = 28;
  localparam int IW = AW - FB;
  localparam int KW = IW + 2;
  localparam int PW = DATA_WIDTH + T + 1;

  localparam logic signed [KW-1:0] ONE    = KW'(1);
  localparam logic [T:0]           W_ONE  = {1'b1, {T{1'b0}}};
  localparam logic [PW-1:0]        HALF   = PW'(1) << (T - 1);

  typedef enum logic {WAIT, EMIT} state_t;

  state_t                 state_reg, state_next;
  logic [AW-1:0]          acc_reg, acc_next;
  logic signed [KW-1:0]   k_reg, k_next;
  logic [15:0]            step_reg;
  logic [DATA_WIDTH-1:0]  p0_reg, p1_reg;
  logic                   hs_d_reg;
  logic                   emit;

  logic                   s1_valid_reg;
  logic [DATA_WIDTH-1:0]  do_reg;
  logic                   de_reg, hs_reg, vs_reg;

  logic                   line_start, accept, idle;
  logic [AW-1:0]          acc_adv;
  logic signed [KW-1:0]   int_cur, int_adv, km1, k_acc, k_acc_m1;

  assign line_start = hs_d_reg & ~bus.hs_i;
  assign accept     = bus.de_i & ~bus.hs_i;
  assign acc_adv    = acc_reg + AW'(step_reg);
  assign int_cur    = $signed({2'b00, acc_reg[AW-1:FB]});
  assign int_adv    = $signed({2'b00, acc_adv[AW-1:FB]});
  assign km1        = k_reg - ONE;
  assign k_acc      = accept ? (k_reg + ONE) : k_reg;
  assign k_acc_m1   = k_acc - ONE;

  // k is the index of p1, so an output at integer position int needs int == k-1.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    k_next     = k_acc;
    emit       = 1'b0;
    if (int_cur < km1) begin
      acc_next = acc_adv;
    end
    case (state_reg)
      WAIT: begin
        if (int_cur == km1) state_next = EMIT;
      end
      EMIT: begin
        if (int_cur == km1) begin
          emit       = 1'b1;
          acc_next   = acc_adv;
          state_next = (int_adv == k_acc_m1) ? EMIT : WAIT;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = WAIT;
    endcase
    if (line_start) begin
      acc_next   = '0;
      k_next     = accept ? '0 : -ONE;
      state_next = WAIT;
      emit       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= WAIT;
      acc_reg   <= '0;
      k_reg     <= -ONE;
      p0_reg    <= '0;
      p1_reg    <= '0;
      step_reg  <= 16'(PIXEL_STEP);
      hs_d_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      k_reg     <= k_next;
      hs_d_reg  <= bus.hs_i;
      if (accept) begin
        p0_reg <= p1_reg;
        p1_reg <= bus.di_i;
      end
      if (line_start) begin
        step_reg <= (scale_step == 16'd0) ? 16'(PIXEL_STEP) : scale_step;
      end
    end
  end

  // Stage 1: one weighted product per tap; tap 0 carries (1-f), tap 1 carries f.
  logic [T-1:0] frac_w;
  assign frac_w = acc_reg[FB-1 -: T];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tap
      logic [DATA_WIDTH-1:0] pix;
      logic [T:0]            wgt;
      logic [PW-1:0]         prod_reg;
      assign pix = (gi == 0) ? p0_reg : p1_reg;
      assign wgt = (gi == 0) ? (W_ONE - {1'b0, frac_w}) : {1'b0, frac_w};
      always_ff @(posedge clk) begin
        if (!rst) begin
          prod_reg <= '0;
        end else if (emit) begin
          prod_reg <= PW'(pix) * PW'(wgt);
        end
      end
    end
  endgenerate

  logic [PW-1:0] sum;
`ifdef SCALER_H_ROUND_EN
  assign sum = g_tap[0].prod_reg + g_tap[1].prod_reg + HALF;
`else
  assign sum = g_tap[0].prod_reg + g_tap[1].prod_reg;
`endif

  // Blanking may only be reported once nothing of the line is left in flight.
  assign idle = (state_reg == WAIT) && !s1_valid_reg && !de_reg && (int_cur != km1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      do_reg       <= '0;
      de_reg       <= 1'b0;
      hs_reg       <= 1'b1;
      vs_reg       <= 1'b1;
    end else begin
      s1_valid_reg <= emit;
      de_reg       <= s1_valid_reg;
      if (s1_valid_reg) do_reg <= sum[T +: DATA_WIDTH];
      vs_reg <= bus.vs_i;
      if (!bus.hs_i) hs_reg <= 1'b0;
      else if (idle) hs_reg <= 1'b1;
    end
  end

  assign bus.do_o = do_reg;
  assign bus.de_o = de_reg;
  assign bus.hs_o = hs_reg;
  assign bus.vs_o = vs_reg;
endmodule

// File: tb/tb_scaler_h_lerp.sv
// Directed bench for scaler_h_lerp: unity, up- and down-scale lines, rounding, reset and sync delay.
module tb_scaler_h_lerp;
  localparam int DW = 8;
  typedef logic [DW-1:0] line_t [8];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] scale_step = 16'd4096;
  int          n_vec = 0;
  int          n_err = 0;

  scaler_h_lerp_if #(.DATA_WIDTH(DW)) bus ();

  scaler_h_lerp #(
    .PIXEL_STEP(4096),
    .TABLE_INPUT_WIDTH(10),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scale_step(scale_step),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] cap_q[$];
  int            hs_rise_at = -1;
  logic          hs_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.hs_o && !hs_prev && hs_rise_at < 0) hs_rise_at = cap_q.size();
    hs_prev = bus.hs_o;
    if (bus.de_o) cap_q.push_back(bus.do_o);
  end

  line_t l_ramp10 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
  line_t l_ramp0  = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
  line_t l_up     = '{8'd0, 8'd100, 8'd200, 8'd240, 8'd252, 8'd128, 8'd64, 8'd0};
  line_t l_tiny   = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [DW-1:0] exp_up [28] = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175,
                                 8'd200, 8'd210, 8'd220, 8'd230, 8'd240, 8'd243, 8'd246, 8'd249,
                                 8'd252, 8'd221, 8'd190, 8'd159, 8'd128, 8'd112, 8'd96, 8'd80,
                                 8'd64, 8'd48, 8'd32, 8'd16};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [15:0] step, input int w, input line_t px,
                           output logic hs_after_fall);
    cap_q.delete();
    hs_rise_at = -1;
    scale_step = step;
    bus.hs_i   = 1'b0;
    tick(1);
    hs_after_fall = bus.hs_o;
    tick(3);
    for (int i = 0; i < w; i++) begin
      bus.di_i = px[i];
      bus.de_i = 1'b1;
      tick(1);
      bus.de_i = 1'b0;
      tick(9);
    end
    bus.hs_i = 1'b1;
    tick(20);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    n_vec++; if (bus.do_o !== 8'd0) begin n_err++; $display("FAIL reset_do got=%0d want=0", bus.do_o); end
    n_vec++; if (bus.de_o !== 1'b0) begin n_err++; $display("FAIL reset_de got=%b want=0", bus.de_o); end
    n_vec++; if (bus.hs_o !== 1'b1) begin n_err++; $display("FAIL reset_hs got=%b want=1", bus.hs_o); end
    n_vec++; if (bus.vs_o !== 1'b1) begin n_err++; $display("FAIL reset_vs got=%b want=1", bus.vs_o); end
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_unity(input logic [15:0] step, input string tag);
    logic hs_f;
    logic [DW-1:0] got;
    send_line(step, 8, l_ramp10, hs_f);
    $display("%s: %0d outputs, hs_o rose after %0d", tag, cap_q.size(), hs_rise_at);
    n_vec++; if (hs_f !== 1'b0) begin n_err++; $display("FAIL %s_hs_fall got=%b want=0", tag, hs_f); end
    n_vec++; if (cap_q.size() != 7) begin n_err++; $display("FAIL %s_count got=%0d want=7", tag, cap_q.size()); end
    n_vec++; if (hs_rise_at != 7) begin n_err++; $display("FAIL %s_hs_rise got=%0d want=7", tag, hs_rise_at); end
    for (int i = 0; i < 7; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_vec++;
      if (got !== DW'(10 * (i + 1))) begin
        n_err++; $display("FAIL %s_px%0d got=%0d want=%0d", tag, i, got, 10 * (i + 1));
      end
    end
  endtask

  task automatic test_upscale();
    logic hs_f;
    logic [DW-1:0] got;
    send_line(16'd1024, 8, l_up, hs_f);
    $display("upscale: %0d outputs", cap_q.size());
    n_vec++; if (cap_q.size() != 28) begin n_err++; $display("FAIL up_count got=%0d want=28", cap_q.size()); end
    for (int i = 0; i < 28; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_vec++;
      if (got !== exp_up[i]) begin n_err++; $display("FAIL up_px%0d got=%0d want=%0d", i, got, exp_up[i]); end
    end
  endtask

  task automatic test_downscale();
    logic hs_f;
    logic [DW-1:0] got;
    send_line(16'd8192, 8, l_ramp0, hs_f);
    $display("downscale: %0d outputs", cap_q.size());
    n_vec++; if (cap_q.size() != 4) begin n_err++; $display("FAIL down_count got=%0d want=4", cap_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_vec++;
      if (got !== DW'(20 * i)) begin n_err++; $display("FAIL down_px%0d got=%0d want=%0d", i, got, 20 * i); end
    end
  endtask

  task automatic test_rounding();
    logic hs_f;
    logic [DW-1:0] got;
    logic [DW-1:0] exp_r [4];
`ifdef SCALER_H_ROUND_EN
    exp_r = '{8'd0, 8'd0, 8'd1, 8'd1};
`else
    exp_r = '{8'd0, 8'd0, 8'd0, 8'd0};
`endif
    send_line(16'd1024, 2, l_tiny, hs_f);
    $display("rounding: %0d outputs", cap_q.size());
    n_vec++; if (cap_q.size() != 4) begin n_err++; $display("FAIL round_count got=%0d want=4", cap_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_vec++;
      if (got !== exp_r[i]) begin n_err++; $display("FAIL round_px%0d got=%0d want=%0d", i, got, exp_r[i]); end
    end
  endtask

  task automatic test_reset_midline();
    cap_q.delete();
    scale_step = 16'd4096;
    bus.vs_i   = 1'b0;
    bus.hs_i   = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      bus.di_i = l_ramp10[i];
      bus.de_i = 1'b1;
      tick(1);
      bus.de_i = 1'b0;
      tick(9);
    end
    rst = 1'b0;
    tick(1);
    $display("reset mid-line: do_o=%0d de_o=%b hs_o=%b vs_o=%b", bus.do_o, bus.de_o, bus.hs_o, bus.vs_o);
    n_vec++; if (bus.do_o !== 8'd0) begin n_err++; $display("FAIL mid_rst_do got=%0d want=0", bus.do_o); end
    n_vec++; if (bus.de_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_de got=%b want=0", bus.de_o); end
    n_vec++; if (bus.hs_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_hs got=%b want=1", bus.hs_o); end
    n_vec++; if (bus.vs_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_vs got=%b want=1", bus.vs_o); end
    bus.hs_i = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    test_unity(16'd4096, "after_reset");
  endtask

  task automatic test_vs_and_zero_step();
    bus.vs_i = 1'b0;
    tick(2);
    n_vec++; if (bus.vs_o !== 1'b0) begin n_err++; $display("FAIL vs_low got=%b want=0", bus.vs_o); end
    bus.vs_i = 1'b1;
    tick(1);
    n_vec++; if (bus.vs_o !== 1'b1) begin n_err++; $display("FAIL vs_rise got=%b want=1", bus.vs_o); end
    bus.vs_i = 1'b0;
    #1;
    n_vec++; if (bus.vs_o !== 1'b1) begin n_err++; $display("FAIL vs_hold got=%b want=1", bus.vs_o); end
    tick(1);
    n_vec++; if (bus.vs_o !== 1'b0) begin n_err++; $display("FAIL vs_fall got=%b want=0", bus.vs_o); end
    $display("vs_o delay: checked");
    test_unity(16'd0, "zero_step");
  endtask

  initial begin
    bus.di_i = '0;
    bus.de_i = 1'b0;
    bus.hs_i = 1'b1;
    bus.vs_i = 1'b0;
    #1;
    test_reset();
    test_unity(16'd4096, "unity");
    test_upscale();
    test_downscale();
    test_rounding();
    test_reset_midline();
    test_vs_and_zero_step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
